// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM state encoding for the bit-serial adder sequencer
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_add_ctrl_full_add_cell.sv
// full_add_cell: combinational 1-bit full adder reusable by serial arithmetic units
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: feeds two W-bit operands LSB-first through a full-add cell with a registered carry
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);
  state_e          state_q;
  logic [W-1:0]    a_q, b_q, out_s_q, sum_d;
  logic [W-2:0]    r_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q, out_cout_q, out_ovf_q, s, co, last;
  full_add_cell u_cell (.a(a_q[0]), .b(b_q[0]), .ci(carry_q), .s(s), .co(co));
  // the partial result holds the W-1 sum bits already produced; the new bit enters at the top
  assign sum_d     = {s, r_q};
  assign last      = cnt_q == CW'(W - 1);
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign busy      = state_q != ST_IDLE;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      out_s_q    <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_b;
          carry_q <= in_cin;
          cnt_q   <= '0;
          r_q     <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          r_q     <= sum_d[W-1:1];
          carry_q <= co;
          cnt_q   <= last ? cnt_q : cnt_q + 1'b1;
          // on the MSB step carry_q is the carry into the MSB, co the carry out of it
          if (last) begin
            out_s_q    <= sum_d;
            out_cout_q <= co;
            out_ovf_q  <= carry_q ^ co;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
